// File: rtl/irda_rx_stream_mux.sv
// irda_rx_stream_mux
//   Routes one of NUM_CH demodulator receive streams into the RX FIFO through
//   a small skid buffer. It also counts frame length in words (for IFDLR),
//   reports frame end/abort pulses and a sticky overrun flag, and lets the
//   routed channel change only between frames.
//
// Ports
//   wb_clk_i, wb_rst_i   clock, async active-low reset
//   mode_sel             requested receive channel
//   rx_restart           synchronous flush / resync (level)
//   ch_dat_i/add/sto/err per-channel word, valid, end-of-frame, error
//   rxfifo_full_i        RX FIFO back-pressure
//   rxfifo_dat_o/add_o   registered push into RX FIFO
//   ifdlr_o              word count of last good frame
//   frame_done_o/err_o   one-cycle frame end / abort pulses
//   overrun_o            sticky word-dropped flag
//   active_ch_o          channel currently routed
//   mode_busy_o          mode switch waiting for frame end
//
// State | meaning
//   S_IDLE        | between frames, channel switch applies immediately
//   S_RECV        | frame in progress on active channel
//   S_SWITCH_PEND | frame in progress, new channel waits for frame end
module irda_rx_stream_mux #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int SKID_DEPTH = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [CH_W-1:0]          mode_sel,
    input  logic                     rx_restart,
    input  logic [NUM_CH*DATA_W-1:0] ch_dat_i,
    input  logic [NUM_CH-1:0]        ch_add_i,
    input  logic [NUM_CH-1:0]        ch_sto_i,
    input  logic [NUM_CH-1:0]        ch_err_i,
    input  logic                     rxfifo_full_i,
    output logic [DATA_W-1:0]        rxfifo_dat_o,
    output logic                     rxfifo_add_o,
    output logic [LEN_W-1:0]         ifdlr_o,
    output logic                     frame_done_o,
    output logic                     frame_err_o,
    output logic                     overrun_o,
    output logic [CH_W-1:0]          active_ch_o,
    output logic                     mode_busy_o
);

    localparam int                 PTR_W     = $clog2(SKID_DEPTH);
    localparam logic [PTR_W:0]     C_DEPTH   = (PTR_W+1)'(SKID_DEPTH);
    localparam logic [LEN_W-1:0]   C_LEN_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_SWITCH_PEND} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [SKID_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic [DATA_W-1:0]   r_dat_o;
    logic                r_add_o;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_ifdlr;
    logic                r_done;
    logic                r_err;
    logic                r_overrun;
    logic [CH_W-1:0]     r_active_ch;
    logic                r_restart_d;

    logic                w_sel_add;
    logic                w_sel_sto;
    logic                w_sel_err;
    logic [DATA_W-1:0]   w_sel_dat;
    logic                w_empty;
    logic                w_full;
    logic                w_req;
    logic                w_pop;
    logic                w_acc;
    logic                w_bypass;
    logic                w_wr;
    logic                w_rd;
    logic [DATA_W-1:0]   w_head;
    logic [LEN_W-1:0]    w_len_inc;
    logic                w_done;
    logic                w_err;
    logic                w_ch_load;

    // Channel select; an active index >= NUM_CH matches nothing.
    always_comb begin
        w_sel_add = 1'b0;
        w_sel_sto = 1'b0;
        w_sel_err = 1'b0;
        w_sel_dat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(r_active_ch) == k) begin
                w_sel_add = ch_add_i[k];
                w_sel_sto = ch_sto_i[k];
                w_sel_err = ch_err_i[k];
                w_sel_dat = ch_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // An incoming word counts as available for the same-cycle read so an
    // empty skid gives one-cycle latency; the cycle after a restart never
    // pushes.
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == C_DEPTH);
    assign w_req     = w_sel_add & ~rx_restart;
    assign w_pop     = ~rx_restart & ~r_restart_d & ~rxfifo_full_i & (~w_empty | w_req);
    assign w_acc     = w_req & (~w_full | w_pop);
    assign w_bypass  = w_empty & w_acc & w_pop;
    assign w_wr      = w_acc & ~w_bypass;
    assign w_rd      = w_pop & ~w_empty;
    assign w_head    = w_empty ? w_sel_dat : r_mem[r_rd_ptr];
    assign w_len_inc = (r_len == C_LEN_MAX) ? r_len : r_len + LEN_W'(1);

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_ch_load   = 1'b0;
        if (rx_restart) begin
            w_state_nxt = S_IDLE;
            w_ch_load   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc)                         w_state_nxt = S_RECV;
                    else if (mode_sel != r_active_ch)  w_ch_load   = 1'b1;
                end
                S_RECV, S_SWITCH_PEND: begin
                    // Frame end is the safe point to apply a pending switch.
                    if (w_sel_err) begin
                        w_err       = 1'b1;
                        w_ch_load   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_sel_sto) begin
                        w_done      = 1'b1;
                        w_ch_load   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (mode_sel != r_active_ch) begin
                        w_state_nxt = S_SWITCH_PEND;
                    end else begin
                        w_state_nxt = S_RECV;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_sel_dat;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_dat_o     <= '0;
            r_add_o     <= 1'b0;
            r_len       <= '0;
            r_ifdlr     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_overrun   <= 1'b0;
            r_active_ch <= '0;
            r_restart_d <= 1'b0;
        end else begin
            r_restart_d <= rx_restart;
            r_add_o     <= w_pop;
            r_done      <= w_done;
            r_err       <= w_err;
            if (w_pop) r_dat_o <= w_head;
            if (w_ch_load) r_active_ch <= mode_sel;
            if (rx_restart) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_len     <= '0;
                r_overrun <= 1'b0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                if (w_wr && !w_rd)      r_count <= r_count + (PTR_W+1)'(1);
                else if (!w_wr && w_rd) r_count <= r_count - (PTR_W+1)'(1);
                if (w_req && !w_acc) r_overrun <= 1'b1;
                // A word accepted alongside the stop belongs to the frame.
                if (w_done) r_ifdlr <= w_acc ? w_len_inc : r_len;
                if (w_done || w_err) r_len <= '0;
                else if (w_acc)      r_len <= w_len_inc;
            end
        end
    end

    assign rxfifo_dat_o = r_dat_o;
    assign rxfifo_add_o = r_add_o;
    assign ifdlr_o      = r_ifdlr;
    assign frame_done_o = r_done;
    assign frame_err_o  = r_err;
    assign overrun_o    = r_overrun;
    assign active_ch_o  = r_active_ch;
    assign mode_busy_o  = (r_state == S_SWITCH_PEND);

endmodule

// File: tb/tb_irda_rx_stream_mux.sv
module tb_irda_rx_stream_mux;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 16;

    logic                     wb_clk_i;
    logic                     wb_rst_i;
    logic [CH_W-1:0]          mode_sel;
    logic                     rx_restart;
    logic [NUM_CH*DATA_W-1:0] ch_dat_i;
    logic [NUM_CH-1:0]        ch_add_i;
    logic [NUM_CH-1:0]        ch_sto_i;
    logic [NUM_CH-1:0]        ch_err_i;
    logic                     rxfifo_full_i;
    logic [DATA_W-1:0]        rxfifo_dat_o;
    logic                     rxfifo_add_o;
    logic [LEN_W-1:0]         ifdlr_o;
    logic                     frame_done_o;
    logic                     frame_err_o;
    logic                     overrun_o;
    logic [CH_W-1:0]          active_ch_o;
    logic                     mode_busy_o;

    int n_checks = 0;
    int n_errors = 0;

    irda_rx_stream_mux #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .SKID_DEPTH(4)
    ) u_dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_i      (wb_rst_i),
        .mode_sel      (mode_sel),
        .rx_restart    (rx_restart),
        .ch_dat_i      (ch_dat_i),
        .ch_add_i      (ch_add_i),
        .ch_sto_i      (ch_sto_i),
        .ch_err_i      (ch_err_i),
        .rxfifo_full_i (rxfifo_full_i),
        .rxfifo_dat_o  (rxfifo_dat_o),
        .rxfifo_add_o  (rxfifo_add_o),
        .ifdlr_o       (ifdlr_o),
        .frame_done_o  (frame_done_o),
        .frame_err_o   (frame_err_o),
        .overrun_o     (overrun_o),
        .active_ch_o   (active_ch_o),
        .mode_busy_o   (mode_busy_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int ch, input logic add, input logic sto, input logic err,
                         input logic [31:0] dat);
        ch_add_i = '0;
        ch_sto_i = '0;
        ch_err_i = '0;
        ch_dat_i = '0;
        ch_add_i[ch] = add;
        ch_sto_i[ch] = sto;
        ch_err_i[ch] = err;
        ch_dat_i[ch*DATA_W +: DATA_W] = dat;
    endtask

    task automatic quiet();
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    // Outputs are sampled 1 time unit after the edge that consumed the inputs.
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        wb_rst_i      = 1'b0;
        mode_sel      = '0;
        rx_restart    = 1'b0;
        rxfifo_full_i = 1'b0;
        quiet();
        repeat (2) @(posedge wb_clk_i);
        #1;
        check("rst_add",    64'(rxfifo_add_o), 64'd0);
        check("rst_active", 64'(active_ch_o),  64'd0);
        check("rst_ifdlr",  64'(ifdlr_o),      64'd0);
        wb_rst_i = 1'b1;

        // Back-to-back frame on ch1, stop with the fifth word.
        mode_sel = 2'd1;
        tick();
        check("sel1_active", 64'(active_ch_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b1, (i == 4), 1'b0, 32'hA0 + 32'(i));
            tick();
            check("bb_add", 64'(rxfifo_add_o), 64'd1);
            check("bb_dat", 64'(rxfifo_dat_o), 64'hA0 + 64'(i));
            if (i < 4) check("bb_done_early", 64'(frame_done_o), 64'd0);
        end
        check("bb_done", 64'(frame_done_o), 64'd1);
        check("bb_ifdlr", 64'(ifdlr_o), 64'd5);
        quiet();
        tick();
        check("bb_done_single", 64'(frame_done_o), 64'd0);
        check("bb_add_end", 64'(rxfifo_add_o), 64'd0);

        // Back-pressure: four fit, words five and six are dropped.
        rxfifo_full_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1'b1, 1'b0, 1'b0, 32'hB0 + 32'(i));
            tick();
            check("bp_nopush", 64'(rxfifo_add_o), 64'd0);
            if (i == 3) check("bp_ovr_before", 64'(overrun_o), 64'd0);
        end
        check("bp_overrun", 64'(overrun_o), 64'd1);
        quiet();
        rxfifo_full_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_drain_add", 64'(rxfifo_add_o), 64'd1);
            check("bp_drain_dat", 64'(rxfifo_dat_o), 64'hB0 + 64'(i));
        end
        tick();
        check("bp_drain_stop", 64'(rxfifo_add_o), 64'd0);
        drive(1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        check("bp_done", 64'(frame_done_o), 64'd1);
        check("bp_ifdlr", 64'(ifdlr_o), 64'd4);
        check("bp_ovr_sticky", 64'(overrun_o), 64'd1);

        // Mid-frame switch request 1 -> 2.
        drive(1, 1'b1, 1'b0, 1'b0, 32'hC0);
        tick();
        check("sw_first", 64'(rxfifo_add_o), 64'd1);
        quiet();
        mode_sel = 2'd2;
        tick();
        check("sw_busy", 64'(mode_busy_o), 64'd1);
        check("sw_active_old", 64'(active_ch_o), 64'd1);
        drive(2, 1'b1, 1'b0, 1'b0, 32'hD0);
        tick();
        check("sw_ch2_ignored", 64'(rxfifo_add_o), 64'd0);
        check("sw_busy_hold", 64'(mode_busy_o), 64'd1);
        drive(1, 1'b1, 1'b1, 1'b0, 32'hC1);
        tick();
        check("sw_last_dat", 64'(rxfifo_dat_o), 64'hC1);
        check("sw_active_new", 64'(active_ch_o), 64'd2);
        check("sw_busy_clear", 64'(mode_busy_o), 64'd0);
        check("sw_done", 64'(frame_done_o), 64'd1);
        check("sw_ifdlr", 64'(ifdlr_o), 64'd2);

        // Error and stop together: abort wins, IFDLR untouched.
        for (int i = 0; i < 3; i++) begin
            drive(2, 1'b1, 1'b0, 1'b0, 32'hE0 + 32'(i));
            tick();
            check("er_dat", 64'(rxfifo_dat_o), 64'hE0 + 64'(i));
        end
        drive(2, 1'b0, 1'b1, 1'b1, 32'h0);
        tick();
        check("er_err", 64'(frame_err_o), 64'd1);
        check("er_no_done", 64'(frame_done_o), 64'd0);
        check("er_ifdlr", 64'(ifdlr_o), 64'd2);
        quiet();
        tick();
        check("er_err_single", 64'(frame_err_o), 64'd0);

        // Restart with three words held and overrun set.
        rxfifo_full_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(2, 1'b1, 1'b0, 1'b0, 32'hF0 + 32'(i));
            tick();
        end
        check("rs_ovr_set", 64'(overrun_o), 64'd1);
        quiet();
        rxfifo_full_i = 1'b0;
        tick();
        check("rs_pop_one", 64'(rxfifo_dat_o), 64'hF0);
        rxfifo_full_i = 1'b1;
        tick();
        check("rs_hold", 64'(rxfifo_add_o), 64'd0);
        rxfifo_full_i = 1'b0;
        mode_sel   = 2'd3;
        rx_restart = 1'b1;
        tick();
        check("rs_nopush0", 64'(rxfifo_add_o), 64'd0);
        check("rs_ovr_clr", 64'(overrun_o), 64'd0);
        check("rs_active", 64'(active_ch_o), 64'd3);
        check("rs_busy", 64'(mode_busy_o), 64'd0);
        check("rs_ifdlr_held", 64'(ifdlr_o), 64'd2);
        rx_restart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_flushed", 64'(rxfifo_add_o), 64'd0);
        end
        drive(3, 1'b1, 1'b0, 1'b0, 32'h77);
        tick();
        check("rs_new_add", 64'(rxfifo_add_o), 64'd1);
        check("rs_new_dat", 64'(rxfifo_dat_o), 64'h77);

        // Async reset mid-frame, between clock edges.
        drive(3, 1'b1, 1'b0, 1'b0, 32'h78);
        tick();
        quiet();
        mode_sel = 2'd0;
        #2;
        wb_rst_i = 1'b0;
        #1;
        check("ar_add",    64'(rxfifo_add_o), 64'd0);
        check("ar_dat",    64'(rxfifo_dat_o), 64'd0);
        check("ar_ifdlr",  64'(ifdlr_o),      64'd0);
        check("ar_active", 64'(active_ch_o),  64'd0);
        check("ar_done",   64'(frame_done_o), 64'd0);
        check("ar_err",    64'(frame_err_o),  64'd0);
        check("ar_ovr",    64'(overrun_o),    64'd0);
        check("ar_busy",   64'(mode_busy_o),  64'd0);
        wb_rst_i = 1'b1;
        tick();
        check("ar_after_active", 64'(active_ch_o), 64'd0);
        check("ar_after_add", 64'(rxfifo_add_o), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
